// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer: LANES bits per beat into a DATA_WIDTH word, skid-buffered output.
// Optional output word_cnt is enabled by defining DESER_WORD_CNT_EN.
`timescale 1ns/1ps

// state | meaning
// FILL  | accepting beats into the assembly register
// FULL  | assembled word waiting for the output slot to drain
module serial_deser #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 1,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    input  logic [LANES-1:0]      in_serial,
    input  logic                  in_start,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_parallel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sync_err
`ifdef DESER_WORD_CNT_EN
    ,
    output logic [15:0]           word_cnt
`endif
);

    localparam int BEATS = DATA_WIDTH / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic {FILL, FULL} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt, pos;
    logic [DATA_WIDTH-1:0] asm_q, asm_nxt, par_nxt;
    logic                  vld_nxt, err_nxt, accept, last, slot_free;

    assign in_ready = (state == FILL);

    always_comb begin
        accept    = in_valid && (state == FILL);
        pos       = in_start ? '0 : cnt;
        slot_free = !out_valid || out_ready;
        last      = accept && (pos == LAST_BEAT);
        asm_nxt   = asm_q;
        cnt_nxt   = cnt;
        state_nxt = state;
        par_nxt   = out_parallel;
        vld_nxt   = out_valid && !out_ready;
        err_nxt   = 1'b0;
        case (state)
            FILL: begin
                if (accept) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (CNT_W'(b) == pos) begin
                            asm_nxt[(MSB_FIRST ? DATA_WIDTH - (b + 1) * LANES : b * LANES) +: LANES] = in_serial;
                        end
                    end
                    err_nxt = in_start && (cnt != '0);
                    if (last) begin
                        cnt_nxt = '0;
                        if (slot_free) begin
                            par_nxt = asm_nxt;
                            vld_nxt = 1'b1;
                        end else begin
                            state_nxt = FULL;
                        end
                    end else begin
                        cnt_nxt = pos + CNT_W'(1);
                    end
                end
            end
            FULL: begin
                // out_valid is still high here, so draining means the parked word takes the slot
                if (out_ready) begin
                    par_nxt   = asm_q;
                    vld_nxt   = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= FILL;
            cnt          <= '0;
            asm_q        <= '0;
            out_parallel <= '0;
            out_valid    <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            asm_q        <= asm_nxt;
            out_parallel <= par_nxt;
            out_valid    <= vld_nxt;
            sync_err     <= err_nxt;
        end
    end

`ifdef DESER_WORD_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_cnt <= '0;
        end else if (out_valid && out_ready) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/serial_deser.md
Name:
serial_deser

Overview:
- Parametrised serial-to-parallel deserializer; next generation of the team's input shift register.
- Collects LANES bits per accepted beat into a DATA_WIDTH word, with selectable bit order and frame-start resync.
- Presents each word on a registered valid/ready output with one-word skid buffering.
- Sits between a serial pad/PRBS source and the GF datapath operand inputs.

Parameters:
- DATA_WIDTH, 32, assembled word width; must be a multiple of LANES.
- LANES, 1, serial bits accepted per beat.
- MSB_FIRST, 0: beat 0 fills the least significant bits. 1: beat 0 fills the most significant bits.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  beat present on in_serial
- in_serial  in  LANES  serial data, lane i = bit i
- in_start  in  1  qualified by in_valid; this beat is beat 0 of a new word
- in_ready  out  1  deserializer accepts a beat this cycle
- out_parallel  out  DATA_WIDTH  assembled word
- out_valid  out  1  out_parallel holds a valid word
- out_ready  in  1  consumer takes the word
- sync_err  out  1  one-cycle pulse: in_start arrived mid-word

Behaviour:
- BEATS = DATA_WIDTH/LANES. Beat counter cnt runs 0..BEATS-1.
- A beat is accepted when in_valid && in_ready.
- Reset (asynchronous, resetn=0):
  - out_parallel=0, out_valid=0, sync_err=0, in_ready=1 (after release).
  - cnt=0, assembly register=0, state=FILL.
  - A partial word is discarded.
- Placement of beat k:
  - MSB_FIRST=0: lane i goes to bit k*LANES+i.
  - MSB_FIRST=1: lane i goes to bit DATA_WIDTH-(k+1)*LANES+i.
- State FILL (in_ready=1):
  - Each accepted beat is written at position cnt, then cnt increments.
  - Accepted beat with in_start=1: written at position 0 and cnt becomes 1. Previously assembled bits are discarded (stale bits may remain and are overwritten by later beats).
  - If in_start arrives with cnt!=0, sync_err=1 on the next cycle.
  - in_start with cnt==0 is normal operation.
  - Last beat (cnt==BEATS-1) with output slot free or draining (out_valid==0 || out_ready==1):
    - Next cycle: out_parallel = completed word, out_valid=1.
    - cnt=0, stay in FILL. Latency from last beat to out_valid is 1 cycle.
  - Last beat with output slot occupied and not draining: go to FULL with the word kept in the assembly register.
- State FULL (in_ready=0):
  - When out_ready=1, the assembled word moves to out_parallel on the next edge; out_valid stays 1, cnt=0, go to FILL.
- Output:
  - out_valid clears after out_valid && out_ready unless a new word loads on the same edge.
  - out_parallel is stable while out_valid && !out_ready.
- Throughput: one word per BEATS cycles, with no bubbles when out_ready is held at 1.
- BEATS==1 is legal: every accepted beat is a complete word.

Optional Feature:
- Macro: DESER_WORD_CNT_EN
- Defined:
  - Adds output word_cnt [15:0], reset 0.
  - Increments on each out_valid && out_ready and wraps 0xFFFF->0.
  - Increments on the same edge the word is consumed.
- Undefined: no port and no logic.

Test Plan:
- DATA_WIDTH=8, LANES=1, MSB_FIRST=0, out_ready=1. Bits 1,0,1,1,0,0,1,0 -> out_parallel=0x4D; out_valid is high for one cycle, the cycle after the 8th beat.
- Same bits with MSB_FIRST=1 -> out_parallel=0xB2.
- DATA_WIDTH=32, LANES=4. Nibbles 1,2,...,8, in_valid held high -> out_parallel=0x87654321 after 8 beats. Back-to-back words must show no idle cycle on in_ready.
- Backpressure, out_ready=0, two words streamed:
  - First word stays on out_parallel.
  - in_ready=0 from the cycle after the second word's last beat.
  - One-cycle out_ready pulse -> second word appears next cycle and in_ready returns to 1.
- Resync, DATA_WIDTH=8:
  - 3 beats, then in_start with bits 1,1,1,1,0,0,0,0 -> sync_err pulse of one cycle; out_parallel=0x0F.
  - in_start at cnt==0 gives no sync_err.
- Async reset:
  - Drop resetn mid-word (after 5 beats) between clock edges -> out_valid/out_parallel go to 0 immediately.
  - A fresh 8-beat word after release assembles correctly.
  - With DESER_WORD_CNT_EN, word_cnt returns to 0 and reaches 3 after three consumed words.
